// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pkg
//  Description : Shared SDRAM definitions for the init, refresh, write, read
//                and arbiter blocks: command encodings {cs_n,ras_n,cas_n,we_n},
//                default timing values and the linear address layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

   // Command encodings {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_READ = 4'b0101;
   localparam logic [3:0] CMD_PRE  = 4'b0010;

   // Default device timing, in clk cycles / words
   localparam int CAS_LAT_DEF   = 3;
   localparam int BURST_LEN_DEF = 4;
   localparam int TRCD_DEF      = 2;
   localparam int TRP_DEF       = 2;

   // Linear word address {bank, row, col}; incrementing it as a plain vector
   // carries col into row and row into bank.
   typedef struct packed {
      logic [1:0]  bank;
      logic [11:0] row;
      logic [8:0]  col;
   } sdram_addr_t;

endpackage
`default_nettype wire

// File: rtl/sdram_rd_capture.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_rd_capture
//  Description : Read-data capture. A CAS_LAT+1 deep shift register carries a
//                per-beat valid flag alongside the SDRAM latency; the data
//                register samples the DQ bus on the edge where a beat's word
//                is on the bus.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                beat_i         - high in every cycle of a read burst
//                dq_i [15:0]    - SDRAM data bus
//                data_o [15:0]  - registered read word
//                vld_o          - data_o qualifier
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_rd_capture #(
   parameter int CAS_LAT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        beat_i,
   input  logic [15:0] dq_i,
   output logic [15:0] data_o,
   output logic        vld_o
);

   logic [CAS_LAT:0] vld_sr_q;
   logic [15:0]      data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_sr_q <= '0;
         data_q   <= 16'h0000;
      end else begin
         vld_sr_q <= {vld_sr_q[CAS_LAT-1:0], beat_i};
         // Tap CAS_LAT-1 is high in the cycle the beat's word is on dq_i;
         // the flag and the word then leave the pipeline together.
         if (vld_sr_q[CAS_LAT-1]) begin
            data_q <= dq_i;
         end
      end
   end

   assign data_o = data_q;
   assign vld_o  = vld_sr_q[CAS_LAT];

endmodule
`default_nettype wire

// File: rtl/sdram_read.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_read
//  Description : SDRAM read job engine. Latches a job (start address, length),
//                requests the bus, opens the row, streams back-to-back READ
//                bursts and closes the row with PRECHARGE-all. A job is split
//                into several bus tenures on column wrap or refresh request,
//                resuming at the saved address.
//  Ports       : clk, rst                  - clock, async active-high reset
//                rd_trig/rd_start_addr/rd_len - job start
//                rd_en, ref_req            - arbiter grant, refresh request
//                rd_req, rd_end, rd_busy   - arbiter handshake / status
//                rd_cmd, rd_bank, rd_addr  - SDRAM command/address bus
//                sdram_dq                  - SDRAM data bus
//                rd_data, rd_data_vld      - read data stream
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_read
   import sdram_pkg::*;
#(
   parameter int CAS_LAT   = CAS_LAT_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int TRCD      = TRCD_DEF,
   parameter int TRP       = TRP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_trig,
   input  logic [22:0] rd_start_addr,
   input  logic [9:0]  rd_len,
   input  logic        rd_en,
   input  logic        ref_req,
   output logic        rd_req,
   output logic        rd_end,
   output logic [3:0]  rd_cmd,
   output logic [1:0]  rd_bank,
   output logic [11:0] rd_addr,
   input  logic [15:0] sdram_dq,
   output logic [15:0] rd_data,
   output logic        rd_data_vld,
   output logic        rd_busy
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_REQ       = 4'd1;
   localparam logic [3:0] S_ACT       = 4'd2;
   localparam logic [3:0] S_TRCD_WAIT = 4'd3;
   localparam logic [3:0] S_READ      = 4'd4;
   localparam logic [3:0] S_DRAIN     = 4'd5;
   localparam logic [3:0] S_PRE       = 4'd6;
   localparam logic [3:0] S_TRP_WAIT  = 4'd7;
   localparam logic [3:0] S_END       = 4'd8;

   // Terminal counts; the wait-state ones are only reached when the delay > 1.
   localparam logic [7:0]  c_BURST_LAST = 8'(BURST_LEN - 1);
   localparam logic [7:0]  c_TRCD_LAST  = 8'(TRCD - 2);
   localparam logic [7:0]  c_TRP_LAST   = 8'(TRP - 2);
   localparam logic [7:0]  c_DRAIN_LAST = 8'(CAS_LAT - 1);
   localparam logic [22:0] c_ADDR_STEP  = 23'(BURST_LEN);
   localparam logic [9:0]  c_LEN_STEP   = 10'(BURST_LEN);

   logic [3:0]  state_q, state_d;
   logic [7:0]  cnt_q,   cnt_d;
   logic [22:0] addr_q,  addr_d;   // address of the next burst to read
   logic [9:0]  rem_q,   rem_d;    // words still to be read
   sdram_addr_t w_addr;

   assign w_addr = addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         addr_q  <= 23'd0;
         rem_q   <= 10'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      case (state_q)
         S_IDLE: begin
            if (rd_trig && (rd_len != 10'd0)) begin
               addr_d  = rd_start_addr;
               rem_d   = rd_len;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (rd_en) begin
               state_d = S_ACT;
            end
         end
         S_ACT: begin
            cnt_d   = 8'd0;
            state_d = (TRCD > 1) ? S_TRCD_WAIT : S_READ;
         end
         S_TRCD_WAIT: begin
            if (cnt_q == c_TRCD_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_READ;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_READ: begin
            // The READ goes out on beat 0, so the pointer moves on there.
            if (cnt_q == 8'd0) begin
               addr_d = addr_q + c_ADDR_STEP;
               rem_d  = rem_q - c_LEN_STEP;
            end
            // Burst boundary: a column of 0 after the step means the row ended.
            if (cnt_q == c_BURST_LAST) begin
               cnt_d = 8'd0;
               if ((rem_d == 10'd0) || (addr_d[8:0] == 9'd0) || ref_req) begin
                  state_d = S_DRAIN;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DRAIN: begin
            // The last burst word is captured on the final edge of this state.
            if (cnt_q == c_DRAIN_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_PRE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_PRE: begin
            cnt_d   = 8'd0;
            state_d = (TRP > 1) ? S_TRP_WAIT : S_END;
         end
         S_TRP_WAIT: begin
            if (cnt_q == c_TRP_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_END;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_END: begin
            state_d = (rem_q != 10'd0) ? S_REQ : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Command bus: NOP with a quiet address unless a command is issued.
   always_comb begin
      rd_cmd  = CMD_NOP;
      rd_bank = 2'b00;
      rd_addr = 12'h000;
      case (state_q)
         S_ACT: begin
            rd_cmd  = CMD_ACT;
            rd_bank = w_addr.bank;
            rd_addr = w_addr.row;
         end
         S_READ: begin
            if (cnt_q == 8'd0) begin
               rd_cmd  = CMD_READ;
               rd_bank = w_addr.bank;
               rd_addr = {3'b000, w_addr.col};
            end
         end
         S_PRE: begin
            rd_cmd  = CMD_PRE;
            rd_addr = 12'h400;   // A10 high: precharge all banks
         end
         default: begin
         end
      endcase
   end

   assign rd_req  = (state_q == S_REQ);
   assign rd_end  = (state_q == S_END);
   assign rd_busy = (state_q != S_IDLE);

   sdram_rd_capture #(
      .CAS_LAT (CAS_LAT)
   ) u_capture (
      .clk    (clk),
      .rst    (rst),
      .beat_i (state_q == S_READ),
      .dq_i   (sdram_dq),
      .data_o (rd_data),
      .vld_o  (rd_data_vld)
   );

endmodule
`default_nettype wire

// File: tb/tb_sdram_read.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_read
//  Description : Self-checking bench for sdram_read. A job-level reference
//                keeps the expected word stream of each accepted job; an SDRAM
//                model answers READ commands after CAS_LAT cycles from an
//                address-derived memory image; a bus monitor checks command
//                timing and addresses against the job's expected next address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_read;

   localparam int CL   = 3;
   localparam int BL   = 4;
   localparam int TRCD = 2;
   localparam int TRP  = 2;

   localparam logic [3:0] C_NOP  = 4'b0111;
   localparam logic [3:0] C_ACT  = 4'b0011;
   localparam logic [3:0] C_READ = 4'b0101;
   localparam logic [3:0] C_PRE  = 4'b0010;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_trig = 1'b0;
   logic [22:0] rd_start_addr = 23'd0;
   logic [9:0]  rd_len = 10'd0;
   logic        rd_en = 1'b1;
   logic        ref_req = 1'b0;
   logic        rd_req, rd_end, rd_data_vld, rd_busy;
   logic [3:0]  rd_cmd;
   logic [1:0]  rd_bank;
   logic [11:0] rd_addr;
   logic [15:0] sdram_dq;
   logic [15:0] rd_data;

   sdram_read #(
      .CAS_LAT (CL), .BURST_LEN (BL), .TRCD (TRCD), .TRP (TRP)
   ) dut (
      .clk (clk), .rst (rst), .rd_trig (rd_trig), .rd_start_addr (rd_start_addr),
      .rd_len (rd_len), .rd_en (rd_en), .ref_req (ref_req), .rd_req (rd_req),
      .rd_end (rd_end), .rd_cmd (rd_cmd), .rd_bank (rd_bank), .rd_addr (rd_addr),
      .sdram_dq (sdram_dq), .rd_data (rd_data), .rd_data_vld (rd_data_vld),
      .rd_busy (rd_busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_vld = 0, n_end = 0, n_act = 0, n_read = 0, n_pre = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference state
   logic [15:0] exp_q[$];          // expected word stream of the running job
   logic [22:0] exp_ptr;           // next address the job must read
   logic [15:0] dq_sched[64];
   logic        dq_has[64];
   logic        vld_sched[64];
   logic [11:0] open_row;
   int          act_cyc, last_rd_cyc, pre_cyc, mon_s;
   bit          act_since, have_rd, have_pre;

   function automatic logic [15:0] mem_word(input logic [22:0] a);
      return a[15:0] ^ {9'd0, a[22:16]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // SDRAM model + bus monitor, mid-cycle
   always @(negedge clk) begin
      mon_s = cyc % 64;
      if (rst) begin
         for (int i = 0; i < 64; i++) begin
            dq_has[i]    = 1'b0;
            vld_sched[i] = 1'b0;
         end
         exp_q.delete();
         act_since = 1'b0;
         have_rd   = 1'b0;
         have_pre  = 1'b0;
         sdram_dq  = 16'hDEAD;
      end else begin
         sdram_dq = dq_has[mon_s] ? dq_sched[mon_s] : 16'hDEAD;
         dq_has[mon_s] = 1'b0;
         chk("vld_timing", 32'(rd_data_vld), 32'(vld_sched[mon_s]));
         vld_sched[mon_s] = 1'b0;
         if (rd_data_vld) begin
            n_vld++;
            chk("word_available", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
         end
         if (rd_end) begin
            n_end++;
            if (have_pre) chk("end_after_pre", 32'(cyc - pre_cyc), 32'(TRP));
            have_pre = 1'b0;
         end
         case (rd_cmd)
            C_NOP: begin
            end
            C_ACT: begin
               n_act++;
               chk("act_bank_row", 32'({rd_bank, rd_addr}), 32'(exp_ptr[22:9]));
               open_row  = rd_addr;
               act_cyc   = cyc;
               act_since = 1'b1;
            end
            C_READ: begin
               n_read++;
               chk("read_a11_9", 32'(rd_addr[11:9]), 32'd0);
               chk("read_loc", 32'({rd_bank, open_row, rd_addr[8:0]}), 32'(exp_ptr));
               if (act_since) chk("trcd", 32'(cyc - act_cyc), 32'(TRCD));
               else if (have_rd) chk("read_spacing", 32'(cyc - last_rd_cyc), 32'(BL));
               for (int i = 0; i < BL; i++) begin
                  dq_sched[(cyc + CL + i) % 64]    = mem_word({rd_bank, open_row, rd_addr[8:0]} + 23'(i));
                  dq_has[(cyc + CL + i) % 64]      = 1'b1;
                  vld_sched[(cyc + CL + 1 + i) % 64] = 1'b1;
               end
               exp_ptr     = exp_ptr + 23'(BL);
               last_rd_cyc = cyc;
               have_rd     = 1'b1;
               act_since   = 1'b0;
            end
            C_PRE: begin
               n_pre++;
               chk("pre_a10", 32'(rd_addr[10]), 32'd1);
               if (have_rd) chk("pre_after_drain", 32'(cyc - last_rd_cyc), 32'(BL + CL));
               have_rd  = 1'b0;
               pre_cyc  = cyc;
               have_pre = 1'b1;
            end
            default: chk("cmd_legal", 32'(rd_cmd), 32'(C_NOP));
         endcase
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      chk("rst_cmd",  32'(rd_cmd), 32'(C_NOP));
      chk("rst_bank", 32'(rd_bank), 32'd0);
      chk("rst_addr", 32'(rd_addr), 32'd0);
      chk("rst_data", 32'(rd_data), 32'd0);
      chk("rst_req",  32'(rd_req), 32'd0);
      chk("rst_end",  32'(rd_end), 32'd0);
      chk("rst_vld",  32'(rd_data_vld), 32'd0);
      chk("rst_busy", 32'(rd_busy), 32'd0);
   endtask

   task automatic start_job(input logic [22:0] a, input logic [9:0] len, input bit accept);
      rd_trig       = 1'b1;
      rd_start_addr = a;
      rd_len        = len;
      if (accept) begin
         exp_ptr = a;
         for (int i = 0; i < int'(len); i++) exp_q.push_back(mem_word(a + 23'(i)));
      end
      tick(1);
      rd_trig       = 1'b0;
      rd_start_addr = $urandom();
      rd_len        = 10'($urandom());
      if (accept) begin
         chk("trig_busy", 32'(rd_busy), 32'd1);
         chk("trig_req",  32'(rd_req), 32'd1);
      end else if (len == 10'd0) begin
         chk("len0_busy", 32'(rd_busy), 32'd0);
         chk("len0_req",  32'(rd_req), 32'd0);
      end
   endtask

   task automatic wait_idle(input int budget, input bit rnd);
      for (int i = 0; i < budget && rd_busy; i++) begin
         if (rnd) begin
            rd_en   = ($urandom_range(0, 3) != 0);
            ref_req = ($urandom_range(0, 4) == 0);
         end
         tick(1);
      end
      rd_en   = 1'b1;
      ref_req = 1'b0;
      chk("job_finished", 32'(rd_busy), 32'd0);
      tick(1);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_cmd_read(input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(1);
         if (rd_cmd == C_READ) found = 1'b1;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   initial begin
      int v0, e0, a0, r0;
      bit found;
      logic [22:0] ra;
      logic [9:0]  rl;

      // Reset state
      tick(3);
      check_reset_outputs();
      rst = 1'b0;
      tick(2);
      check_reset_outputs();

      // Single row, two bursts from address 0
      v0 = n_vld; e0 = n_end; a0 = n_act; r0 = n_read;
      start_job(23'd0, 10'd8, 1'b1);
      wait_idle(200, 1'b0);
      chk("basic_words", 32'(n_vld - v0), 32'd8);
      chk("basic_ends",  32'(n_end - e0), 32'd1);
      chk("basic_acts",  32'(n_act - a0), 32'd1);
      chk("basic_reads", 32'(n_read - r0), 32'd2);

      // Column wrap at 508 carries into the next row
      v0 = n_vld; e0 = n_end; a0 = n_act;
      start_job({2'd1, 12'd5, 9'd508}, 10'd8, 1'b1);
      wait_idle(200, 1'b0);
      chk("wrap_words", 32'(n_vld - v0), 32'd8);
      chk("wrap_ends",  32'(n_end - e0), 32'd2);
      chk("wrap_acts",  32'(n_act - a0), 32'd2);

      // Refresh preemption during the first burst
      v0 = n_vld; e0 = n_end;
      start_job(23'd0, 10'd16, 1'b1);
      wait_cmd_read("pre_first_read");
      ref_req = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick(1);
         if (rd_end) found = 1'b1;
      end
      chk("preempt_end_seen", 32'(found), 32'd1);
      ref_req = 1'b0;
      tick(1);
      chk("preempt_rereq", 32'(rd_req), 32'd1);
      wait_idle(400, 1'b0);
      chk("preempt_words", 32'(n_vld - v0), 32'd16);
      chk("preempt_ends",  32'(n_end - e0), 32'd2);

      // Trigger while busy is ignored; zero-length trigger is ignored
      v0 = n_vld;
      start_job({2'd2, 12'd77, 9'd32}, 10'd8, 1'b1);
      tick(2);
      start_job({2'd3, 12'd9, 9'd100}, 10'd16, 1'b0);
      wait_idle(300, 1'b0);
      chk("busy_trig_words", 32'(n_vld - v0), 32'd8);
      start_job({2'd1, 12'd1, 9'd0}, 10'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("len0_cmd", 32'(rd_cmd), 32'(C_NOP));
         chk("len0_idle", 32'(rd_busy), 32'd0);
         tick(1);
      end

      // Grant withheld for 50 cycles
      v0 = n_vld;
      rd_en = 1'b0;
      start_job({2'd0, 12'd300, 9'd64}, 10'd12, 1'b1);
      for (int i = 0; i < 50; i++) begin
         tick(1);
         chk("nogrant_req", 32'(rd_req), 32'd1);
         chk("nogrant_cmd", 32'(rd_cmd), 32'(C_NOP));
      end
      rd_en = 1'b1;
      wait_idle(300, 1'b0);
      chk("nogrant_words", 32'(n_vld - v0), 32'd12);

      // Reset during READ, then a fresh job
      start_job({2'd2, 12'd1000, 9'd256}, 10'd32, 1'b1);
      wait_cmd_read("rst_read_seen");
      rst = 1'b1;
      #1;
      check_reset_outputs();
      tick(2);
      rst = 1'b0;
      tick(1);
      v0 = n_vld;
      start_job({2'd3, 12'd4095, 9'd500}, 10'd20, 1'b1);
      wait_idle(600, 1'b0);
      chk("post_rst_words", 32'(n_vld - v0), 32'd20);

      // Randomized jobs with random grant and refresh pressure
      for (int j = 0; j < 8; j++) begin
         ra[22:21] = 2'($urandom());
         ra[20:9]  = 12'($urandom());
         ra[8:0]   = (j % 2 == 0) ? 9'(508 - 4 * $urandom_range(0, 3))
                                  : {7'($urandom()), 2'b00};
         rl = 10'(4 * $urandom_range(1, 16));
         v0 = n_vld;
         start_job(ra, rl, 1'b1);
         wait_idle(3000, 1'b1);
         chk("rand_words", 32'(n_vld - v0), 32'(rl));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sdram_read.md
SDRAM_READ -- requirements
Module: sdram_read

Interface
REQ-001 Parameter CAS_LAT, default 3: SDRAM CAS latency in clk cycles.
REQ-002 Parameter BURST_LEN, default 4: words per READ command; fixed burst length.
REQ-003 Parameter TRCD, default 2: ACTIVE-to-READ delay in clk cycles.
REQ-004 Parameter TRP, default 2: PRECHARGE-to-idle delay in clk cycles.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 rd_trig  input  1  one-cycle pulse that starts a read job.
REQ-008 rd_start_addr  input  23  job start address {bank[1:0], row[11:0], col[8:0]}, sampled with rd_trig.
REQ-009 rd_len  input  10  job length in words, multiple of 4, sampled with rd_trig; 0 means ignore the trigger.
REQ-010 rd_en  input  1  arbiter grant; level.
REQ-011 ref_req  input  1  refresh request from the refresh block; level.
REQ-012 rd_req  output  1  request to the arbiter.
REQ-013 rd_end  output  1  one-cycle pulse when the module releases the bus.
REQ-014 rd_cmd  output  4  {cs_n, ras_n, cas_n, we_n}.
REQ-015 rd_bank  output  2  SDRAM bank address.
REQ-016 rd_addr  output  12  SDRAM address bus.
REQ-017 sdram_dq  input  16  SDRAM data bus, read side.
REQ-018 rd_data  output  16  registered read word.
REQ-019 rd_data_vld  output  1  rd_data qualifier.
REQ-020 rd_busy  output  1  a job is pending or in progress.

Function
REQ-021 Commands SHALL be NOP=0111, ACT=0011, READ=0101, PRE=0010; PRE SHALL drive rd_addr[10]=1 (precharge all).
REQ-022 An accepted rd_trig SHALL latch address and length, set rd_busy, and raise rd_req on the next cycle; rd_trig while rd_busy SHALL be ignored.
REQ-023 States: IDLE, REQ, ACT, TRCD_WAIT, READ, DRAIN, PRE, TRP_WAIT, END.
REQ-024 REQ: hold rd_req high until rd_en=1, then go to ACT and drop rd_req.
REQ-025 ACT: issue ACT for one cycle with bank and row; TRCD_WAIT holds NOP for TRCD-1 cycles.
REQ-026 READ: issue READ with rd_addr[8:0]=current column and rd_addr[11:9]=0; then issue NOP for BURST_LEN-1 cycles; advance the column by 4 and the remaining count by 4.
REQ-027 Reads SHALL be back to back, one READ every BURST_LEN cycles, while remaining>0, the column has not wrapped, and ref_req=0.
REQ-028 Loop exit: on remaining=0, column wrap from 508 to 0 (row+1, row carries into bank), or ref_req=1 sampled at a burst boundary, go to DRAIN.
REQ-029 DRAIN: NOP until the last burst word is captured; then PRE for one cycle; then TRP_WAIT for TRP-1 cycles; then END.
REQ-030 END: pulse rd_end for one cycle. If remaining>0, return to REQ with rd_req=1 and resume at the saved address. Otherwise clear rd_busy and go to IDLE.
REQ-031 Data: rd_data SHALL equal sdram_dq sampled CAS_LAT+1 clk edges after the READ cycle. rd_data_vld SHALL be high for exactly BURST_LEN consecutive cycles per READ.
REQ-032 rd_data_vld count SHALL equal rd_len per job; no word is dropped or duplicated across preemption or wrap.
REQ-033 rd_cmd SHALL be NOP in every cycle without an explicit command.
REQ-034 ref_req raised during ACT/TRCD_WAIT SHALL still allow at least one burst before exit.

Reset
REQ-035 Reset SHALL force state IDLE, rd_cmd=0111, rd_bank=0, rd_addr=0, rd_data=0, and rd_req, rd_end, rd_data_vld, rd_busy=0.
REQ-036 Reset mid-job SHALL abandon the job and clear the data pipeline; nothing is resumed.

Structure
REQ-037 The command encodings and the CAS/TRCD/TRP/BURST_LEN defaults SHALL live in a shared sdram_pkg, also used by the init, refresh, write and arbiter blocks.
REQ-038 Read-data capture SHALL be one sub-module, sdram_rd_capture: a CAS_LAT+1-deep valid shift register plus the data register.

Verification
REQ-039 rd_trig with addr {0,0,0}, len 8, rd_en granted, and a model holding 0x0000..0x0007 -> ACT, READ col 0, READ col 4, PRE, rd_end; 8 vld words in order.
REQ-040 len 8 at col 508 -> first burst at row r col 508; second burst after PRE/ACT at row r+1 col 0; two rd_end pulses.
REQ-041 ref_req raised during the first burst of a len-16 job -> exit after that burst, PRE, rd_end; rd_req re-asserted; resumes at col 4; total 16 words.
REQ-042 rd_trig while busy, and rd_trig with len 0 -> no state change and no rd_req.
REQ-043 rst asserted during READ -> all outputs at reset values immediately; new rd_trig after release runs normally.
REQ-044 rd_en withheld for 50 cycles -> rd_req held high; rd_cmd NOP throughout; no bus activity.
